axi4_master: RTL

Single-outstanding AXI4 initiator that converts a simple command/stream interface into AXI4 INCR bursts. It drives the write address, write data, write response, read address and read data channels of the team's memory-mapped AXI4 slave. It is the stimulus-side counterpart of that slave in block-level integration and in the verification environment. One transaction is in flight at a time; reads and writes never overlap.

---
 rtl/axi4_master_if.sv | 40 ++++
 rtl/axi4_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/axi4_master_if.sv
// AXI4 channel bundle between the single-outstanding initiator and a memory-mapped slave.
interface axi4_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WLAST;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RLAST;
  logic                  RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WVALID, WLAST, BREADY,
           ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID, RLAST
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WVALID, WLAST, BREADY,
           ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID, RLAST
  );
endinterface

// File: rtl/axi4_master.sv
// Single-outstanding AXI4 initiator: turns one command plus a beat stream into one INCR burst.
module axi4_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  axi4_master_if.master         axi
);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            beatCnt_q, beatCnt_d;
  logic [1:0]            resp_q, resp_d;
  logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d, arAddr_q, arAddr_d;
  logic [7:0]            awLen_q, awLen_d, arLen_q, arLen_d;
  logic [2:0]            awSize_q, awSize_d, arSize_q, arSize_d;
  logic                  rLastExpected;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      beatCnt_q <= '0;
      resp_q    <= '0;
      awAddr_q  <= '0;
      awLen_q   <= '0;
      awSize_q  <= '0;
      arAddr_q  <= '0;
      arLen_q   <= '0;
      arSize_q  <= '0;
    end else begin
      state_q   <= state_d;
      beatCnt_q <= beatCnt_d;
      resp_q    <= resp_d;
      awAddr_q  <= awAddr_d;
      awLen_q   <= awLen_d;
      awSize_q  <= awSize_d;
      arAddr_q  <= arAddr_d;
      arLen_q   <= arLen_d;
      arSize_q  <= arSize_d;
    end
  end

  assign axi.AWADDR  = awAddr_q;
  assign axi.AWLEN   = awLen_q;
  assign axi.AWSIZE  = awSize_q;
  assign axi.ARADDR  = arAddr_q;
  assign axi.ARLEN   = arLen_q;
  assign axi.ARSIZE  = arSize_q;
  assign axi.WDATA   = wr_data;
  assign rd_data     = axi.RDATA;
  assign rLastExpected = (beatCnt_q == arLen_q);

  always_comb begin
    state_d     = state_q;
    beatCnt_d   = beatCnt_q;
    resp_d      = resp_q;
    awAddr_d    = awAddr_q;
    awLen_d     = awLen_q;
    awSize_d    = awSize_q;
    arAddr_d    = arAddr_q;
    arLen_d     = arLen_q;
    arSize_d    = arSize_q;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    done        = 1'b0;
    done_resp   = 2'b00;
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.WLAST   = 1'b0;
    axi.BREADY  = 1'b0;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          beatCnt_d = '0;
          resp_d    = 2'b00;
          if (cmd_write) begin
            awAddr_d = cmd_addr;
            awLen_d  = cmd_len;
            awSize_d = cmd_size;
            state_d  = AW;
          end else begin
            arAddr_d = cmd_addr;
            arLen_d  = cmd_len;
            arSize_d = cmd_size;
            state_d  = AR;
          end
        end
      end
      AW: begin
        axi.AWVALID = 1'b1;
        if (axi.AWREADY) state_d = W;
      end
      W: begin
        axi.WVALID = wr_valid;
        wr_ready   = axi.WREADY;
        axi.WLAST  = (beatCnt_q == awLen_q);
        if (wr_valid && axi.WREADY) begin
          beatCnt_d = beatCnt_q + 8'd1;
          if (axi.WLAST) state_d = B;
        end
      end
      B: begin
        axi.BREADY = 1'b1;
        if (axi.BVALID) begin
          resp_d  = axi.BRESP;
          state_d = DONE;
        end
      end
      AR: begin
        axi.ARVALID = 1'b1;
        if (axi.ARREADY) state_d = R;
      end
      R: begin
        axi.RREADY = rd_ready;
        rd_valid   = axi.RVALID;
        rd_last    = axi.RLAST;
        if (axi.RVALID && rd_ready) begin
          beatCnt_d = beatCnt_q + 8'd1;
          resp_d    = (axi.RRESP > resp_q) ? axi.RRESP : resp_q;
          // A slave that disagrees with us about where the burst ends is a protocol error.
          if (axi.RLAST != rLastExpected) resp_d = 2'b10;
          if (axi.RLAST || rLastExpected) state_d = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        done_resp = resp_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
